// File: rtl/id_ex_bypass_stage.sv
// IF/ID + ID/EX pipeline registers with operand bypass muxing and hazard statistics.
// Latency: ID operands reach EX one clock after selection; pc_en is combinational.
// Backpressure: stall holds IF/ID and drops PC enable; ID/EX never holds (bubbles instead).
module id_ex_bypass_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] if_pc,
  input  logic [DATA_W-1:0] if_ir,
  output logic [DATA_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_ir,
  input  logic [DATA_W-1:0] id_r1_data,
  input  logic [DATA_W-1:0] id_r2_data,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_wreg,
  input  logic [1:0]        R1Forward,
  input  logic [1:0]        R2Forward,
  input  logic [DATA_W-1:0] ex_fwd_data,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_taken,
  input  logic              clr_cnt,
  output logic              pc_en,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [4:0]        ex_wreg,
  output logic              ex_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  fwd_cnt
);

  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_EX  = 2'b10;

  logic [DATA_W-1:0] r_id_pc;
  logic [DATA_W-1:0] r_id_ir;
  logic [DATA_W-1:0] r_ex_pc;
  logic [DATA_W-1:0] r_ex_a;
  logic [DATA_W-1:0] r_ex_b;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic [4:0]        r_ex_wreg;
  logic              r_ex_valid;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic [CNT_W-1:0]  r_fwd_cnt;

  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;
  logic              w_r1_fwd;
  logic              w_r2_fwd;
  logic [1:0]        w_fwd_add;
  logic              w_bubble;
  logic              w_stall_evt;

  // A taken branch overrides a stall: the stalled instruction is wrong-path anyway.
  assign pc_en       = ~stall | branch_taken;
  assign w_bubble    = flush | branch_taken;
  assign w_stall_evt = stall & ~branch_taken;

  // Bypass selection for both operands; the reserved code 11 falls back to the register file.
  always_comb begin
    w_opa = id_r1_data;
    w_opb = id_r2_data;
    case (R1Forward)
      SEL_MEM: w_opa = mem_fwd_data;
      SEL_EX:  w_opa = ex_fwd_data;
      default: w_opa = id_r1_data;
    endcase
    case (R2Forward)
      SEL_MEM: w_opb = mem_fwd_data;
      SEL_EX:  w_opb = ex_fwd_data;
      default: w_opb = id_r2_data;
    endcase
  end

  // Number of operands actually taken from a bypass path this cycle (0..2).
  assign w_r1_fwd  = (R1Forward == SEL_MEM) || (R1Forward == SEL_EX);
  assign w_r2_fwd  = (R2Forward == SEL_MEM) || (R2Forward == SEL_EX);
  assign w_fwd_add = {1'b0, w_r1_fwd} + {1'b0, w_r2_fwd};

  // IF/ID register: branch clears to NOP, stall holds, otherwise capture the fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_pc <= '0;
      r_id_ir <= '0;
    end else if (branch_taken) begin
      r_id_pc <= '0;
      r_id_ir <= '0;
    end else if (!stall) begin
      r_id_pc <= if_pc;
      r_id_ir <= if_ir;
    end
  end

  // ID/EX register: bubble on flush/branch, otherwise load the bypassed operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_pc    <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_ctrl  <= '0;
      r_ex_wreg  <= '0;
      r_ex_valid <= 1'b0;
    end else if (w_bubble) begin
      r_ex_pc    <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_ctrl  <= '0;
      r_ex_wreg  <= '0;
      r_ex_valid <= 1'b0;
    end else begin
      r_ex_pc    <= r_id_pc;
      r_ex_a     <= w_opa;
      r_ex_b     <= w_opb;
      r_ex_ctrl  <= id_ctrl;
      r_ex_wreg  <= id_wreg;
      r_ex_valid <= 1'b1;
    end
  end

  // Wrapping statistics counters; a clear wins over any increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else if (clr_cnt) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_stall_evt)  r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (branch_taken) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (!w_bubble)    r_fwd_cnt   <= r_fwd_cnt + CNT_W'(w_fwd_add);
    end
  end

  assign id_pc     = r_id_pc;
  assign id_ir     = r_id_ir;
  assign ex_pc     = r_ex_pc;
  assign ex_a      = r_ex_a;
  assign ex_b      = r_ex_b;
  assign ex_ctrl   = r_ex_ctrl;
  assign ex_wreg   = r_ex_wreg;
  assign ex_valid  = r_ex_valid;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign fwd_cnt   = r_fwd_cnt;

endmodule
